// File: rtl/core_pcr_top.sv
// core_pcr_top: program-counter register feeding the instruction fetch unit.
// Sequential PCs are issued with a valid/ready handshake. Issue pauses while a
// decoded branch is pending. A resolved taken branch redirects the PC and
// pulses a flush. A misaligned target parks the block in a sticky halt.
module core_pcr_top #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        pcr_tx_valid,
  output logic [31:0] pcr_tx_pc,
  input  logic        pcr_tx_ready,
  output logic        pcr_tx_flush,
  input  logic        pcr_rx_bc_pend,
  input  logic        pcr_rx_bc_done,
  input  logic        pcr_rx_bc_taken,
  input  logic [31:0] pcr_rx_bc_addr,
  output logic        pcr_tx_halt
);

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    RUN     = 2'd1,
    WAIT_BC = 2'd2,
    HALT    = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_valid;
  logic        r_flush;
  logic        r_halt;

  state_t      w_next_state;
  logic [31:0] w_next_pc;
  logic        w_next_flush;
  logic        w_redirect;
  logic        w_aligned;

  // A taken branch resolution; its target must be word aligned to be usable.
  assign w_redirect = pcr_rx_bc_done && pcr_rx_bc_taken;
  assign w_aligned  = (pcr_rx_bc_addr[1:0] == 2'b00);

  // Next-state and next-PC selection; redirect outranks transfer and bc_pend.
  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    w_next_flush = 1'b0;
    unique case (r_state)
      BOOT: begin
        w_next_state = RUN;
        w_next_pc    = RESET_PC;
      end
      RUN: begin
        if (w_redirect && w_aligned) begin
          w_next_pc    = pcr_rx_bc_addr;
          w_next_flush = 1'b1;
        end else if (w_redirect) begin
          w_next_state = HALT;
        end else begin
          // valid is always high in RUN, so ready alone marks a transfer.
          if (pcr_tx_ready) begin
            w_next_pc = r_pc + PC_STEP;
          end
          if (pcr_rx_bc_pend) begin
            w_next_state = WAIT_BC;
          end
        end
      end
      WAIT_BC: begin
        if (pcr_rx_bc_done) begin
          if (!pcr_rx_bc_taken) begin
            w_next_state = RUN;
          end else if (w_aligned) begin
            w_next_state = RUN;
            w_next_pc    = pcr_rx_bc_addr;
            w_next_flush = 1'b1;
          end else begin
            w_next_state = HALT;
          end
        end
      end
      HALT: begin
        w_next_state = HALT;
      end
      default: begin
        w_next_state = BOOT;
      end
    endcase
  end

  // State and output registers; outputs are decoded from the next state so
  // they change in the same cycle as the state itself.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= BOOT;
      r_pc    <= RESET_PC;
      r_valid <= 1'b0;
      r_flush <= 1'b0;
      r_halt  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_next_pc;
      r_valid <= (w_next_state == RUN);
      r_flush <= w_next_flush;
      r_halt  <= (w_next_state == HALT);
    end
  end

  assign pcr_tx_valid = r_valid;
  assign pcr_tx_pc    = r_pc;
  assign pcr_tx_flush = r_flush;
  assign pcr_tx_halt  = r_halt;

endmodule

// File: tb/tb_core_pcr_top.sv
// Bench for core_pcr_top: directed scenarios then randomized traffic, each
// cycle compared against a flag-based behavioural model of the PC register.
module tb_core_pcr_top;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] STEP   = 32'd4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        valid;
  logic [31:0] pc;
  logic        ready;
  logic        flush;
  logic        bc_pend;
  logic        bc_done;
  logic        bc_taken;
  logic [31:0] bc_addr;
  logic        halt;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state
  bit          m_started;
  bit          m_waiting;
  bit          m_halted;
  bit          m_flush;
  logic [31:0] m_pc;

  core_pcr_top #(.RESET_PC(RST_PC), .PC_STEP(STEP)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .pcr_tx_valid    (valid),
    .pcr_tx_pc       (pc),
    .pcr_tx_ready    (ready),
    .pcr_tx_flush    (flush),
    .pcr_rx_bc_pend  (bc_pend),
    .pcr_rx_bc_done  (bc_done),
    .pcr_rx_bc_taken (bc_taken),
    .pcr_rx_bc_addr  (bc_addr),
    .pcr_tx_halt     (halt)
  );

  always #5 clk = ~clk;

  // Advance the model by one clock edge using the inputs the DUT saw.
  task automatic model_step();
    m_flush = 1'b0;
    if (!rstn) begin
      m_started = 1'b0;
      m_waiting = 1'b0;
      m_halted  = 1'b0;
      m_pc      = RST_PC;
    end else if (m_halted) begin
      // sticky until reset
    end else if (!m_started) begin
      m_started = 1'b1;
      m_pc      = RST_PC;
    end else if (m_waiting) begin
      if (bc_done) begin
        if (!bc_taken) begin
          m_waiting = 1'b0;
        end else if ((bc_addr % 4) == 0) begin
          m_pc      = bc_addr;
          m_flush   = 1'b1;
          m_waiting = 1'b0;
        end else begin
          m_halted = 1'b1;
        end
      end
    end else begin
      if (bc_done && bc_taken) begin
        if ((bc_addr % 4) == 0) begin
          m_pc    = bc_addr;
          m_flush = 1'b1;
        end else begin
          m_halted = 1'b1;
        end
      end else begin
        if (ready) m_pc = m_pc + STEP;
        if (bc_pend) m_waiting = 1'b1;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: edge, model update, sample 1 time unit later, compare all outputs.
  task automatic tick(input string tag);
    bit exp_valid;
    @(posedge clk);
    model_step();
    #1;
    exp_valid = m_started && !m_waiting && !m_halted;
    check({tag, ".valid"}, {31'd0, valid}, {31'd0, exp_valid});
    check({tag, ".flush"}, {31'd0, flush}, {31'd0, m_flush});
    check({tag, ".halt"},  {31'd0, halt},  {31'd0, m_halted});
    if (exp_valid || m_halted || !m_started) begin
      check({tag, ".pc"}, pc, m_pc);
    end
  endtask

  task automatic idle_inputs();
    bc_pend  = 1'b0;
    bc_done  = 1'b0;
    bc_taken = 1'b0;
    bc_addr  = 32'h0;
  endtask

  initial begin
    rstn  = 1'b0;
    ready = 1'b0;
    idle_inputs();
    m_started = 1'b0; m_waiting = 1'b0; m_halted = 1'b0;
    m_flush = 1'b0; m_pc = RST_PC;

    // Reset state
    tick("rst0");
    tick("rst1");
    check("rst.pc_const", pc, 32'h0000_0000);
    check("rst.valid_const", {31'd0, valid}, 32'd0);

    // Release with ready high: BOOT, then 0,4,8
    rstn  = 1'b1;
    ready = 1'b1;
    tick("boot");
    check("first_pc", pc, 32'h0);
    check("first_valid", {31'd0, valid}, 32'd1);
    tick("seq4");
    check("seq4_pc", pc, 32'd4);
    tick("seq8");
    check("seq8_pc", pc, 32'd8);

    // Backpressure at pc=8 for three cycles
    ready = 1'b0;
    repeat (3) tick("stall");
    check("stall_pc", pc, 32'd8);
    ready = 1'b1;
    tick("resume");
    check("resume_pc", pc, 32'd12);
    tick("to16");
    check("pc16", pc, 32'd16);

    // bc_pend at pc=16, taken redirect to 0x100 three cycles later
    bc_pend = 1'b1;
    tick("pend");
    check("pend_valid", {31'd0, valid}, 32'd0);
    bc_pend = 1'b0;
    tick("wait1");
    tick("wait2");
    bc_done = 1'b1; bc_taken = 1'b1; bc_addr = 32'h100;
    tick("redir_wait");
    check("redir_pc", pc, 32'h100);
    check("redir_flush", {31'd0, flush}, 32'd1);
    idle_inputs();
    tick("post_redir");
    check("flush_clear", {31'd0, flush}, 32'd0);

    // Redirect in RUN with ready low
    ready = 1'b0;
    bc_done = 1'b1; bc_taken = 1'b1; bc_addr = 32'h40;
    tick("redir_run");
    check("redir_run_pc", pc, 32'h40);
    idle_inputs();
    tick("hold40");

    // Not-taken resolution while waiting, and not-taken in RUN
    bc_pend = 1'b1; ready = 1'b1;
    tick("pend2");
    bc_pend = 1'b0; bc_done = 1'b1; bc_taken = 1'b0; bc_addr = 32'h500;
    tick("nt_wait");
    tick("nt_run");
    idle_inputs();

    // Wrap at top of address space
    ready = 1'b0;
    bc_done = 1'b1; bc_taken = 1'b1; bc_addr = 32'hFFFF_FFFC;
    tick("to_top");
    idle_inputs();
    ready = 1'b1;
    tick("wrap");
    check("wrap_pc", pc, 32'h0000_0000);

    // Misaligned target: halt is sticky
    ready = 1'b0;
    bc_done = 1'b1; bc_taken = 1'b1; bc_addr = 32'h102;
    tick("misalign");
    check("halt_set", {31'd0, halt}, 32'd1);
    bc_addr = 32'h200; bc_pend = 1'b1; ready = 1'b1;
    repeat (4) tick("halted");
    idle_inputs();
    rstn = 1'b0;
    tick("halt_rst");
    check("halt_cleared", {31'd0, halt}, 32'd0);
    rstn = 1'b1;
    tick("reboot");

    // Randomized traffic with occasional resets and misaligned targets
    for (int i = 0; i < 600; i++) begin
      rstn     = ($urandom_range(0, 59) != 0);
      ready    = $urandom_range(0, 3) != 0;
      bc_pend  = ($urandom_range(0, 7) == 0);
      bc_done  = ($urandom_range(0, 5) == 0);
      bc_taken = $urandom_range(0, 1) != 0;
      bc_addr  = $urandom;
      if ($urandom_range(0, 15) != 0) bc_addr[1:0] = 2'b00;
      tick("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
